// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED effect sequencer.
package led_seq_pkg;

  localparam int TMR_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    WAIT,
    NEXT
  } state_t;

  function automatic int step_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_seq_table.sv
// Pattern/duration register file: one sync write port, one comb read port.
module led_seq_table
  import led_seq_pkg::*;
#(
  parameter int N_LEDS  = 8,
  parameter int N_STEPS = 8,
  parameter int STEP_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [STEP_W-1:0] waddr,
  input  logic [N_LEDS-1:0] wpattern,
  input  logic [TMR_W-1:0]  wduration,
  input  logic [STEP_W-1:0] raddr,
  output logic [N_LEDS-1:0] rpattern,
  output logic [TMR_W-1:0]  rduration
);

  logic [N_LEDS-1:0] pattern  [N_STEPS];
  logic [TMR_W-1:0]  duration [N_STEPS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_STEPS; i++) begin
        pattern[i]  <= '0;
        duration[i] <= '0;
      end
    end else if (we) begin
      pattern[waddr]  <= wpattern;
      duration[waddr] <= wduration;
    end
  end

  assign rpattern  = pattern[raddr];
  assign rduration = duration[raddr];

endmodule

// File: rtl/led_effect_sequencer.sv
// Step sequencer driving LEDs from a (pattern, duration) table via a timer.
// Define LED_SEQ_LOOP_EN to honour the loop input; otherwise runs are one-shot.
module led_effect_sequencer
  import led_seq_pkg::*;
#(
  parameter  int N_LEDS  = 8,
  parameter  int N_STEPS = 8,
  localparam int STEP_W  = step_w(N_STEPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [STEP_W-1:0] cfg_addr,
  input  logic [N_LEDS-1:0] cfg_pattern,
  input  logic [TMR_W-1:0]  cfg_duration,
  input  logic [STEP_W-1:0] cfg_last,
  input  logic              loop,
  input  logic              start,
  input  logic              stop,
  output logic              tmr_reset,
  output logic [TMR_W-1:0]  tmr_limit,
  output logic              tmr_limit_we,
  output logic              tmr_enable,
  input  logic              tmr_done,
  output logic [N_LEDS-1:0] leds,
  output logic [STEP_W-1:0] step_idx,
  output logic              busy,
  output logic              seq_done
);

  localparam logic [STEP_W:0] LAST_MAX = (STEP_W+1)'(N_STEPS - 1);

  state_t            state, state_n;
  logic [STEP_W-1:0] idx_n;
  logic [STEP_W-1:0] last_q;
  logic              loop_q;
  logic              loop_en;
  logic              last_step;
  logic              abort;
  logic              done_n;
  logic [N_LEDS-1:0] rd_pattern;
  logic [TMR_W-1:0]  rd_duration;

  led_seq_table #(
    .N_LEDS  (N_LEDS),
    .N_STEPS (N_STEPS),
    .STEP_W  (STEP_W)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .we        (cfg_we),
    .waddr     (cfg_addr),
    .wpattern  (cfg_pattern),
    .wduration (cfg_duration),
    .raddr     (step_idx),
    .rpattern  (rd_pattern),
    .rduration (rd_duration)
  );

`ifdef LED_SEQ_LOOP_EN
  assign loop_en = loop_q;
`else
  logic unused_loop;
  assign unused_loop = loop_q;
  assign loop_en     = 1'b0;
`endif

  assign abort     = stop && (state != IDLE);
  assign last_step = (step_idx >= last_q);

  always_comb begin
    state_n = state;
    idx_n   = step_idx;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = CLEAR;
          idx_n   = '0;
        end
      end
      CLEAR: state_n = LOAD;
      LOAD:  state_n = WAIT;
      WAIT: begin
        if (tmr_done) state_n = NEXT;
      end
      NEXT: begin
        if (!last_step) begin
          idx_n   = step_idx + 1'b1;
          state_n = CLEAR;
        end else if (loop_en) begin
          idx_n   = '0;
          state_n = CLEAR;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // stop overrides every other transition, including tmr_done
    if (abort) begin
      state_n = IDLE;
      idx_n   = step_idx;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      step_idx     <= '0;
      last_q       <= '0;
      loop_q       <= 1'b0;
      busy         <= 1'b0;
      seq_done     <= 1'b0;
      tmr_reset    <= 1'b0;
      tmr_limit_we <= 1'b0;
      tmr_enable   <= 1'b0;
      tmr_limit    <= '0;
      leds         <= '0;
    end else begin
      state        <= state_n;
      step_idx     <= idx_n;
      busy         <= (state_n != IDLE);
      seq_done     <= done_n;
      tmr_reset    <= (state_n == CLEAR);
      tmr_limit_we <= (state_n == LOAD);
      tmr_enable   <= (state_n == WAIT);
      if (state == IDLE && state_n == CLEAR) begin
        loop_q <= loop;
        if ({1'b0, cfg_last} > LAST_MAX) last_q <= LAST_MAX[STEP_W-1:0];
        else                             last_q <= cfg_last;
      end
      if (state_n == LOAD)  tmr_limit <= rd_duration;
      else if (abort)       tmr_limit <= '0;
      if (abort)            leds <= '0;
      else if (state == LOAD) leds <= rd_pattern;
    end
  end

endmodule

// File: tb/tb_led_effect_sequencer.sv
// Directed bench for led_effect_sequencer paired with a sticky-done timer model.
module tb_led_effect_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [7:0]  cfg_pattern = '0;
  logic [31:0] cfg_duration = '0;
  logic [2:0]  cfg_last = '0;
  logic        loop = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        tmr_reset, tmr_limit_we, tmr_enable, tmr_done;
  logic [31:0] tmr_limit;
  logic [7:0]  leds;
  logic [2:0]  step_idx;
  logic        busy, seq_done;

  int n_checks = 0;
  int n_pass = 0;
  int n_done = 0;
  int n_overlap = 0;
  int cyc = 0;
  logic [7:0] prev;
  logic [7:0] q_pat[$];
  int         q_t[$];

  logic [31:0] cnt, lim;

  always #5 clk = ~clk;

  led_effect_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_pattern  (cfg_pattern),
    .cfg_duration (cfg_duration),
    .cfg_last     (cfg_last),
    .loop         (loop),
    .start        (start),
    .stop         (stop),
    .tmr_reset    (tmr_reset),
    .tmr_limit    (tmr_limit),
    .tmr_limit_we (tmr_limit_we),
    .tmr_enable   (tmr_enable),
    .tmr_done     (tmr_done),
    .leds         (leds),
    .step_idx     (step_idx),
    .busy         (busy),
    .seq_done     (seq_done)
  );

  // timer: done is sticky; with limit d it rises d+1 enabled cycles in
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      lim      <= '0;
      tmr_done <= 1'b0;
    end else if (tmr_reset) begin
      cnt      <= '0;
      tmr_done <= 1'b0;
    end else begin
      if (tmr_limit_we) lim <= tmr_limit;
      if (tmr_enable && !tmr_done) begin
        if (cnt == lim) tmr_done <= 1'b1;
        else            cnt <= cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (leds != prev) begin
      q_pat.push_back(leds);
      q_t.push_back(cyc);
      prev = leds;
    end
    if (seq_done) n_done++;
    if (tmr_reset && tmr_limit_we) n_overlap++;
  endtask

  task automatic clear_rec();
    q_pat.delete();
    q_t.delete();
    prev   = leds;
    n_done = 0;
    cyc    = 0;
  endtask

  function automatic logic [31:0] pat_at(input int i);
    return (i < q_pat.size()) ? 32'(q_pat[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] gap(input int i);
    return (i < q_t.size()) ? 32'(q_t[i] - q_t[i-1]) : 32'hDEAD;
  endfunction

  task automatic wr(input logic [2:0] a, input logic [7:0] p,
                    input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_pattern = p; cfg_duration = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_seq(input logic [2:0] last, input logic lp);
    cfg_last = last; loop = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin tick(); n++; end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_leds(input string tag, input logic [7:0] v);
    int n = 0;
    while (leds != v && n < 300) begin tick(); n++; end
    check(tag, 32'(leds), 32'(v));
  endtask

  initial begin
    prev = 8'h00;
    tick();
    tick();
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tmr", {tmr_reset, tmr_limit_we, tmr_enable, seq_done},
          32'd0);
    check("rst_limit", tmr_limit, 32'd0);
    reset = 1'b0;
    tick();
    wr(3'd0, 8'h01, 32'd5);
    wr(3'd1, 8'h02, 32'd3);
    wr(3'd2, 8'hFF, 32'd0);

    // one-shot run
    clear_rec();
    start_seq(3'd2, 1'b0);
    check("c1_treset", 32'(tmr_reset), 32'd1);
    check("c1_busy", 32'(busy), 32'd1);
    tick();
    check("c2_we", {tmr_reset, tmr_limit_we}, 32'd1);
    check("c2_limit", tmr_limit, 32'd5);
    tick();
    check("c3_leds", 32'(leds), 32'h01);
    check("c3_en", 32'(tmr_enable), 32'd1);
    wait_idle("t1_idle");
    repeat (4) tick();
    check("t1_p1", pat_at(1), 32'h02);
    check("t1_p2", pat_at(2), 32'hFF);
    check("t1_len0", gap(1), 32'd10);
    check("t1_len1", gap(2), 32'd8);
    check("t1_done", 32'(n_done), 32'd1);
    check("t1_hold", 32'(leds), 32'hFF);

    // loop run
    clear_rec();
    start_seq(3'd2, 1'b1);
`ifdef LED_SEQ_LOOP_EN
    begin
      int n = 0;
      while (q_pat.size() < 4 && n < 300) begin tick(); n++; end
    end
    check("t2_wrap", pat_at(3), 32'h01);
    check("t2_idx", 32'(step_idx), 32'd0);
    check("t2_nodone", 32'(n_done), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t2_stop", {busy, leds}, 32'd0);
`else
    wait_idle("t2_idle");
    tick();
    check("t2_oneshot", 32'(n_done), 32'd1);
    check("t2_hold", 32'(leds), 32'hFF);
`endif

    // stop during step 1 WAIT
    clear_rec();
    start_seq(3'd2, 1'b0);
    wait_leds("t3_wait", 8'h02);
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_leds", 32'(leds), 32'd0);
    check("t3_tmr", {tmr_reset, tmr_limit_we, tmr_enable}, 32'd0);
    repeat (10) tick();
    check("t3_nodone", 32'(n_done), 32'd0);

    // overwrite entry 1 while step 0 runs
    clear_rec();
    start_seq(3'd2, 1'b0);
    wait_leds("t4_s0", 8'h01);
    wr(3'd1, 8'h80, 32'd2);
    wait_idle("t4_idle");
    tick();
    check("t4_pat", pat_at(1), 32'h80);
    check("t4_len0", gap(1), 32'd10);
    check("t4_len1", gap(2), 32'd7);
    check("t4_done", 32'(n_done), 32'd1);

    // start+stop in IDLE, then start while busy
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    check("t5_idle", {busy, tmr_reset}, 32'd0);
    check("t5_leds", 32'(leds), 32'hFF);
    clear_rec();
    start_seq(3'd2, 1'b0);
    wait_leds("t5_s0", 8'h01);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_same", {busy, tmr_enable, step_idx}, 32'h18);
    wait_idle("t5_idle");
    tick();
    check("t5_len0", gap(1), 32'd10);
    check("t5_done", 32'(n_done), 32'd1);

    // async reset mid-WAIT
    clear_rec();
    start_seq(3'd2, 1'b0);
    wait_leds("t6_s0", 8'h01);
    #2 reset = 1'b1;
    #1;
    check("t6_leds", 32'(leds), 32'd0);
    check("t6_outs", {busy, tmr_enable, tmr_reset, tmr_limit_we, step_idx},
          32'd0);
    check("t6_limit", tmr_limit, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t6_idle", 32'(busy), 32'd0);

    // table was cleared by reset: step 0 is (0x00, 0)
    clear_rec();
    start_seq(3'd0, 1'b0);
    tick();
    check("t6_tbl_lim", {tmr_limit_we, tmr_limit[30:0]}, 32'h8000_0000);
    wait_idle("t6_tbl_idle");
    tick();
    check("t6_tbl_done", 32'(n_done), 32'd1);
    check("t6_tbl_leds", 32'(leds), 32'd0);

    check("no_overlap", 32'(n_overlap), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_effect_sequencer.md
# led_effect_sequencer

Step sequencer that drives the LED bank from a small programmable table of (pattern, duration) entries. It is the initiator side of the timer interface: for every step it clears the `counter` timer, loads its limit, holds enable high, and waits for `limit_reached`. It then advances to the next step. It sits between the configuration register block and the LED output pins.

## Interface
- `N_LEDS`, default 8: LED pattern width.
- `N_STEPS`, default 8: table depth; `STEP_W = $clog2(N_STEPS)`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state and outputs.
- `cfg_we` input 1: table write strobe.
- `cfg_addr` input `STEP_W`: table entry index.
- `cfg_pattern` input `N_LEDS`: LED pattern for the entry.
- `cfg_duration` input 32: timer limit for the entry.
- `cfg_last` input `STEP_W`: index of the final step; sampled on `start`.
- `loop` input 1: restart at step 0 after the final step; sampled on `start`.
- `start` input 1: begin the sequence; level-sampled.
- `stop` input 1: abort the sequence; level-sampled.
- `tmr_reset` output 1: synchronous clear to the timer.
- `tmr_limit` output 32: limit value to the timer.
- `tmr_limit_we` output 1: limit write strobe to the timer.
- `tmr_enable` output 1: timer count enable.
- `tmr_done` input 1: the timer's `limit_reached`, which is sticky until `tmr_reset`.
- `leds` output `N_LEDS`: registered LED drive.
- `step_idx` output `STEP_W`: current step.
- `busy` output 1: high in every state except IDLE.
- `seq_done` output 1: one-cycle pulse when a one-shot sequence completes.

## Operation
- **Reset values:** FSM = IDLE. Outputs `leds`, `step_idx`, `busy`, `seq_done`, `tmr_*` all 0. Table contents are also 0.
- **Table writes:**
  - A write with `cfg_we` high is accepted in any state.
  - The new entry takes effect the next time that step enters LOAD.
  - A write does not alter `leds` for the step already loaded.
- **FSM states:**
  - IDLE:
    - `start` with `stop` low: latch `cfg_last` and `loop`, set `step_idx`=0, go to CLEAR.
    - Otherwise stay in IDLE.
  - CLEAR: `tmr_reset`=1 for exactly one cycle, then go to LOAD.
  - LOAD: `tmr_limit` = duration[`step_idx`] and `tmr_limit_we`=1 for one cycle; `leds` <= pattern[`step_idx`]. Then go to WAIT.
  - WAIT:
    - `tmr_enable`=1 continuously.
    - When `tmr_done`=1, go to NEXT.
  - NEXT, with `tmr_enable`=0:
    - If `step_idx` < latched last: `step_idx`++, go to CLEAR.
    - Else if latched `loop`=1: `step_idx`=0, go to CLEAR.
    - Else: `seq_done`=1 for one cycle, go to IDLE, and `leds` holds the final pattern.
- **Stop:** `stop` in any non-IDLE state sends the FSM to IDLE on the next edge. All `tmr_*` outputs go to 0, `leds` <= 0, and `seq_done` is not pulsed.
- **Simultaneous events:**
  - `stop` and `start` together: `stop` wins.
  - `start` while busy: ignored.
  - `stop` and `tmr_done` together in WAIT: `stop` wins.
- **Arithmetic:**
  - Durations pass through unmodified.
  - Duration 0 is legal; the step lasts only the timer's minimum latency.
  - `step_idx` never exceeds the latched last step. If the latched last step ≥ `N_STEPS`, it is clamped to `N_STEPS-1`.
- **Stale done:** CLEAR always precedes WAIT, so a sticky `tmr_done` from a previous step is never sampled.

## Timing
- Cycle relationships:
  - `start` sampled at edge 0.
  - CLEAR during cycle 1.
  - LOAD during cycle 2.
  - `leds` valid and WAIT entered from cycle 3.
- Per-step overhead on the sequencer side is 3 cycles (NEXT, CLEAR, LOAD), plus the timer's own latency from enable to done.
- All outputs are registered; there is no combinational path from input to output.
- `tmr_limit_we` and `tmr_reset` are never high in the same cycle.
- The reset value of every output is 0.

## Configuration
- `LED_SEQ_LOOP_EN` defined: the `loop` input is honoured as described above.
- `LED_SEQ_LOOP_EN` undefined:
  - The `loop` port remains but is ignored.
  - Every sequence is one-shot: it ends with `seq_done` and returns to IDLE.

## Structure
- Package `led_seq_pkg` holds:
  - the state enum (IDLE, CLEAR, LOAD, WAIT, NEXT);
  - the timer width constant (32);
  - the step-width helper function.
- Sub-module `led_seq_table` contains:
  - a `N_STEPS`-entry register file for pattern and duration;
  - one synchronous write port;
  - one combinational read port indexed by `step_idx`.

## Test plan
The bench pairs the block with the existing `counter` timer.
- Steps 0/1/2 = (0x01,5), (0x02,3), (0xFF,0), `cfg_last`=2, `loop`=0, `start` pulse. Required response: `leds` goes 0x01 → 0x02 → 0xFF, then one `seq_done` pulse; `leds` stays 0xFF; `busy` drops.
- Same table, `loop`=1 with `LED_SEQ_LOOP_EN` defined. Required response: after step 2, `step_idx` returns to 0 and `leds`=0x01, with no `seq_done`. With the macro undefined, the sequence ends as one-shot.
- `stop` asserted during step 1 WAIT. Required response: next cycle IDLE, `leds`=0, `tmr_enable`=0, no `seq_done`.
- Overwrite entry 1 with (0x80,2) while step 0 runs. Required response: step 1 shows 0x80 and lasts the shorter duration.
- `start` and `stop` in the same cycle while in IDLE, and `start` while busy. Required response: both are ignored and the FSM state is unchanged.
- Assert `reset` asynchronously mid-WAIT. Required response: all outputs are 0 immediately, without waiting for a clock edge; the FSM is in IDLE.
